// File: rtl/conv_pkg.sv
// Shared geometry, widths and state encodings for the conv engine and its readers.
// Result image is M x M with M = N-P+1; NUM results read in raster order.
package conv_pkg;

  localparam int N      = 5;
  localparam int P      = 3;
  localparam int M      = N - P + 1;
  localparam int NUM    = M * M;
  localparam int OUT_W  = 12;
  localparam int ADDR_W = 4;
  localparam int RC_W   = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ,
    DRAIN
  } rd_state_t;

  typedef struct packed {
    logic            last;
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;
  } rc_tag_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    rc_tag_t          tag;
  } beat_t;

endpackage

// File: rtl/conv_stream_fifo.sv
// Fall-through sync FIFO: a push into an empty FIFO is visible the same cycle.
// Ports: push/wdata in, valid/rdata/ready out-stream, count = stored words.
module conv_stream_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   ready,
  output logic                   valid,
  output logic [W-1:0]           rdata,
  output logic [$clog2(D+1)-1:0] count
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  if (D < 2 || (D & (D - 1)) != 0) begin : g_bad_depth
    $error("conv_stream_fifo: D must be a power of 2, >= 2");
  end

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          empty;
  logic          wr;
  logic          rd;

  assign empty = (count == '0);
  // a word consumed in the cycle it arrives never gets stored
  assign wr    = push & ~(empty & ready);
  assign rd    = ~empty & ready;
  assign valid = ~empty | push;

  always_comb begin
    rdata = '0;
    if (!empty)   rdata = mem[rp];
    else if (push) rdata = wdata;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end

endmodule

// File: rtl/conv_result_reader.sv
// Reads the NUM conv results after the engine sweep; emits a tagged valid/ready stream.
// Ports: start/busy/done control, eng_infer/eng_addr/eng_out engine, m_* stream out.
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int WAIT_CYC = 128,
  parameter int FIFO_D   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              eng_infer,
  output logic [ADDR_W-1:0] eng_addr,
  input  logic [OUT_W-1:0]  eng_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic [RC_W-1:0]   m_row,
  output logic [RC_W-1:0]   m_col,
  output logic              m_last
);

  localparam int WC_W  = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam int FC_W  = $clog2(FIFO_D + 1);
  localparam int OCC_W = $clog2(FIFO_D + RD_LAT + 2) + 1;
  localparam int BW    = $bits(beat_t);

  if ((2 ** ADDR_W) < NUM) begin : g_bad_addr
    $error("conv_result_reader: ADDR_W too small for NUM");
  end

  rd_state_t         state;
  logic [WC_W-1:0]   wcnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [RC_W-1:0]   row;
  logic [RC_W-1:0]   col;
  rc_tag_t           issue_tag;
  logic [RD_LAT-1:0] pipe;
  rc_tag_t           tag_pipe [RD_LAT];
  logic [FC_W-1:0]   fifo_count;
  logic [OCC_W-1:0]  occ;
  beat_t             push_beat;
  beat_t             out_beat;
  logic              push;
  logic              pop;
  logic              accept;
  logic              go_read;
  logic              credit;
  logic              issue;
  logic              last_issue;
  logic              fin;

  assign push      = pipe[RD_LAT-1];
  assign pop       = m_valid & m_ready;
  assign push_beat = {eng_out, tag_pipe[RD_LAT-1]};

  // Slots claimed once this edge settles: reads still short of the
  // FIFO plus what the FIFO will hold. Counting the pop lets a
  // FIFO_D = RD_LAT+1 buffer sustain one beat per clock.
  always_comb begin
    occ = OCC_W'(eng_infer) + OCC_W'(fifo_count) + OCC_W'(push);
    for (int i = 0; i < RD_LAT - 1; i++) occ = occ + OCC_W'(pipe[i]);
    occ = occ - OCC_W'(pop);
  end

  assign credit     = occ < OCC_W'(FIFO_D);
  assign accept     = (state == IDLE) & start & ~done;
  // the first issue shares the edge that leaves WAIT (or IDLE)
  assign go_read    = (state == READ)
                    | ((state == WAIT) & (wcnt == WC_W'(1)))
                    | (accept & (WAIT_CYC == 0));
  assign issue      = go_read & credit;
  assign last_issue = rd_addr == ADDR_W'(NUM - 1);
  assign fin        = (state == DRAIN) & pop & m_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      eng_infer <= 1'b0;
      eng_addr  <= '0;
      wcnt      <= '0;
      rd_addr   <= '0;
      row       <= '0;
      col       <= '0;
      issue_tag <= '0;
    end else begin
      done      <= 1'b0;
      eng_infer <= issue;
      if (issue) begin
        eng_addr  <= rd_addr;
        issue_tag <= '{last: last_issue, row: row, col: col};
        rd_addr   <= rd_addr + ADDR_W'(1);
        if (col == RC_W'(M - 1)) begin
          col <= '0;
          row <= row + RC_W'(1);
        end else begin
          col <= col + RC_W'(1);
        end
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            wcnt  <= WC_W'(WAIT_CYC);
            state <= (WAIT_CYC == 0) ? READ : WAIT;
          end
        end
        WAIT: begin
          wcnt <= wcnt - WC_W'(1);
          if (wcnt == WC_W'(1)) state <= READ;
        end
        READ: ;
        DRAIN: begin
          if (fin) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            rd_addr <= '0;
            row     <= '0;
            col     <= '0;
          end
        end
      endcase
      if (issue && last_issue) state <= DRAIN;
    end
  end

  // in-flight marks and their tags travel with the engine latency
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      pipe[0]     <= eng_infer;
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i]     <= pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  conv_stream_fifo #(
    .W (BW),
    .D (FIFO_D)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_beat),
    .ready (m_ready),
    .valid (m_valid),
    .rdata (out_beat),
    .count (fifo_count)
  );

  assign m_data = out_beat.data;
  assign m_row  = out_beat.tag.row;
  assign m_col  = out_beat.tag.col;
  assign m_last = out_beat.tag.last;

endmodule
